ram_rr_arbiter: RTL and testbench
=================================

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 Parameter DWIDTH, default 32: RAM data width in bits.
REQ-002 Parameter AWIDTH, default 8: RAM address width in bits.
REQ-003 Parameter DEPTH, default 256: RAM word count; SHALL equal 2**AWIDTH.
REQ-004 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 req_valid  input  2: per-requester request valid (bit i = requester i).
REQ-007 req_ready  output  2: per-requester acceptance; a request is accepted in the cycle where valid and ready are both 1.
REQ-008 req_we  input  2: per-requester write enable (1 = write, 0 = read).
REQ-009 req_addr0 / req_addr1  input  AWIDTH each: request address.
REQ-010 req_wdata0 / req_wdata1  input  DWIDTH each: write data.
REQ-011 resp_valid  output  2: per-requester read-response valid.
REQ-012 resp_rdata  output  DWIDTH: read data, shared by both requesters; qualified by resp_valid.

Function
REQ-013 The block SHALL own one internal single-port RAM (asynchronous read, synchronous write) and grant at most one request per cycle.
REQ-014 req_ready SHALL be one-hot or zero and combinational from req_valid and the priority pointer; req_ready[i] SHALL never be 1 while req_valid[i] is 0.
REQ-015 Only requester i valid: req_ready[i]=1 in that cycle, regardless of pointer.
REQ-016 Both valid: the requester indicated by the 1-bit priority pointer SHALL be granted; the other SHALL see req_ready=0 and holds its request.
REQ-017 After any grant to requester i, the pointer SHALL point to requester 1-i on the next cycle; with no grant the pointer SHALL hold.
REQ-018 Granted write: RAM word at the granted address SHALL be updated with the granted wdata at the end of that cycle; no response is generated.
REQ-019 Granted read: resp_valid[i] SHALL be 1 exactly one cycle after acceptance, with resp_rdata = RAM word at that address as of the acceptance cycle; latency fixed at 1.
REQ-020 resp_valid SHALL be one-hot or zero; responses have no backpressure; consumers must capture in the valid cycle.
REQ-021 When no read was accepted in the previous cycle, resp_valid SHALL be 0 and resp_rdata SHALL hold its last value.
REQ-022 A read accepted in the cycle after a write to the same address (either requester) SHALL return the new data.
REQ-023 Back-to-back grants SHALL sustain one accepted request per cycle; with both requesters continuously valid, grants SHALL alternate 0,1,0,1,...
REQ-024 Address out of range cannot occur (DEPTH = 2**AWIDTH); no error signalling.

Reset
REQ-025 During rst=1: req_ready=2'b00, no RAM write occurs, pointer SHALL be set to requester 0.
REQ-026 On the cycle after rst: resp_valid=2'b00 and resp_rdata=0; a read accepted in the cycle before rst asserted SHALL produce no response.
REQ-027 RAM contents SHALL NOT be reset.

Structure
REQ-028 All state elements (pointer, response valid, response data) SHALL be built from the team register library (REGISTER_R / REGISTER_R_CE); RAM SHALL be the team RAM module.
REQ-029 A shared package ram_arb_pkg SHALL hold requester count (2) and the response-latency constant (1).
REQ-030 Grant logic SHALL be one sub-module, rr_arb2 (inputs valid[1:0], ptr; output grant[1:0]), purely combinational.

Verification
REQ-031 Reset, then req0 write addr 0x10 data 0xDEADBEEF, next cycle req1 read 0x10 -> req_ready=01 then 10; resp_valid=10 one cycle later with resp_rdata=0xDEADBEEF.
REQ-032 Both continuously valid reading 0x01/0x02 for 6 cycles after reset -> grants 01,10,01,10,01,10; responses alternate with correct data.
REQ-033 Pointer at requester 1, only req0 valid -> req0 granted immediately; pointer then at requester 1.
REQ-034 Read accepted at cycle N, rst asserted at N+1 -> resp_valid=00 at N+1 and N+2; pointer=0 after reset.
REQ-035 req1 holds a write 0x20<-0x55 while req0 wins a read of 0x20 in the same cycle -> req0 gets old data, req1 accepted next cycle; subsequent read returns 0x55.
REQ-036 Idle (no valid) for 4 cycles -> req_ready=00, resp_valid=00, resp_rdata unchanged, pointer unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester RAM arbiter.
// Holds the requester count and the fixed read-response latency.
package ram_arb_pkg;

    localparam int NUM_REQ  = 2;
    localparam int RESP_LAT = 1;

endpackage

// File: rtl/ram_arb_lib.sv
// Team storage primitives: plain and clock-enabled registers with
// synchronous active-high reset, and a single-port RAM.
//   REGISTER_R    : clk, rst, d[N], q[N]
//   REGISTER_R_CE : clk, rst, ce, d[N], q[N]
//   RAM_1P        : clk, we, addr, wdata, rdata (async read, sync write)
module REGISTER_R #(
    parameter int             N    = 1,
    parameter logic [N-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= INIT;
        else     q <= d;
    end
endmodule

module REGISTER_R_CE #(
    parameter int             N    = 1,
    parameter logic [N-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= INIT;
        else if (ce) q <= d;
    end
endmodule

module RAM_1P #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);
    logic [DWIDTH-1:0] mem [DEPTH];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: valid[1:0] requests, ptr = favoured requester, grant[1:0] one-hot/zero.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    // A lone requester always wins; on contention ptr decides.
    assign grant[0] = valid[0] & (~valid[1] | ~ptr);
    assign grant[1] = valid[1] & (~valid[0] |  ptr);
endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter giving two requesters shared access to one RAM.
// Ports: clk, rst (sync, active-high); per-requester valid/ready/we/addr/wdata;
// resp_valid[1:0] one cycle after a granted read, shared resp_rdata.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] req_we,
    input  logic [AWIDTH-1:0]  req_addr0,
    input  logic [AWIDTH-1:0]  req_addr1,
    input  logic [DWIDTH-1:0]  req_wdata0,
    input  logic [DWIDTH-1:0]  req_wdata1,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic [DWIDTH-1:0]  resp_rdata
);
    logic               ptr;
    logic               ptr_next;
    logic [NUM_REQ-1:0] arb_valid;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rd_grant;
    logic [NUM_REQ-1:0] rv_q;
    logic               ram_we;
    logic [AWIDTH-1:0]  ram_addr;
    logic [DWIDTH-1:0]  ram_wdata;
    logic [DWIDTH-1:0]  ram_rdata;

    // Nothing is granted while in reset, so no RAM write can happen.
    assign arb_valid = req_valid & {NUM_REQ{~rst}};

    rr_arb2 u_arb (
        .valid (arb_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign rd_grant  = grant & ~req_we;
    assign ram_we    = |(grant & req_we);
    assign ram_addr  = grant[1] ? req_addr1  : req_addr0;
    assign ram_wdata = grant[1] ? req_wdata1 : req_wdata0;

    RAM_1P #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // After a grant, favour the other requester; otherwise hold.
    assign ptr_next = (|grant) ? grant[0] : ptr;

    REGISTER_R #(.N(1)) u_ptr (
        .clk (clk),
        .rst (rst),
        .d   (ptr_next),
        .q   (ptr)
    );

    REGISTER_R #(.N(NUM_REQ)) u_rv (
        .clk (clk),
        .rst (rst),
        .d   (rd_grant),
        .q   (rv_q)
    );

    // Read data is captured only on a granted read so it holds otherwise.
    REGISTER_R_CE #(.N(DWIDTH)) u_rd (
        .clk (clk),
        .rst (rst),
        .ce  (|rd_grant),
        .d   (ram_rdata),
        .q   (resp_rdata)
    );

    // A read accepted just before reset must not surface while rst is high.
    assign resp_valid = rv_q & {NUM_REQ{~rst}};
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed plus randomized bench for ram_rr_arbiter.
// Behavioural model: array RAM, integer priority, one pending response.
module tb_ram_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_addr0;
    logic [7:0]  req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;

    ram_rr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    bit          m_known [256];
    int          m_ptr;
    logic [1:0]  m_rv;
    logic [31:0] m_rd;
    bit          m_rd_known;

    logic [1:0]  last_ready;
    logic [1:0]  last_rv;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input logic [1:0] v, input logic [1:0] we,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        int w;
        logic [7:0]  a;
        logic [1:0]  exp_ready;
        rst = r; req_valid = v; req_we = we;
        req_addr0 = a0; req_addr1 = a1;
        req_wdata0 = d0; req_wdata1 = d1;
        #1;
        w = -1;
        if (!r) begin
            if (v == 2'b11)  w = m_ptr;
            else if (v[0])   w = 0;
            else if (v[1])   w = 1;
        end
        exp_ready = (w < 0) ? 2'b00 : 2'(1 << w);
        check("ready", 32'(req_ready), 32'(exp_ready));
        check("resp_valid", 32'(resp_valid), r ? 32'd0 : 32'(m_rv));
        if (m_rd_known) check("resp_rdata", resp_rdata, m_rd);
        last_ready = req_ready;
        last_rv    = resp_valid;
        last_rd    = resp_rdata;
        @(posedge clk);
        if (r) begin
            m_rv = 2'b00; m_rd = '0; m_rd_known = 1; m_ptr = 0;
        end else begin
            m_rv = 2'b00;
            if (w >= 0) begin
                a = (w == 1) ? a1 : a0;
                if (we[w]) begin
                    m_mem[a]   = (w == 1) ? d1 : d0;
                    m_known[a] = 1;
                end else begin
                    m_rv       = 2'(1 << w);
                    m_rd       = m_mem[a];
                    m_rd_known = m_known[a];
                end
                m_ptr = 1 - w;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] held;
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        m_ptr = 0; m_rv = 2'b00; m_rd = '0; m_rd_known = 0;
        rst = 1; req_valid = 0; req_we = 0;
        req_addr0 = 0; req_addr1 = 0; req_wdata0 = 0; req_wdata1 = 0;
        @(negedge clk);

        // Reset
        step(1, 2'b11, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        check("rst_ready", 32'(last_ready), 32'h0);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        idle();
        check("post_rst_rdata", last_rd, 32'h0);
        check("post_rst_rv", 32'(last_rv), 32'h0);

        // Write then read by the other requester
        step(0, 2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0);
        check("wr_ready", 32'(last_ready), 32'h1);
        step(0, 2'b10, 2'b00, 8'h00, 8'h10, 32'h0, 32'h0);
        check("rd_ready", 32'(last_ready), 32'h2);
        idle();
        check("rd_rv", 32'(last_rv), 32'h2);
        check("rd_data", last_rd, 32'hDEADBEEF);

        // Seed 0x01/0x02, reset, then continuous contention
        step(0, 2'b01, 2'b01, 8'h01, 8'h00, 32'hA1A1A1A1, 32'h0);
        step(0, 2'b10, 2'b10, 8'h00, 8'h02, 32'h0, 32'hB2B2B2B2);
        step(1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(0, 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
            check("alt_grant", 32'(last_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                check("alt_rv", 32'(last_rv), (k % 2 == 0) ? 32'h2 : 32'h1);
                check("alt_rd", last_rd,
                      (k % 2 == 0) ? 32'hB2B2B2B2 : 32'hA1A1A1A1);
            end
        end
        idle();

        // Pointer at requester 1, lone req0 still wins, pointer stays at 1
        step(0, 2'b01, 2'b00, 8'h01, 8'h00, 32'h0, 32'h0);
        step(0, 2'b01, 2'b00, 8'h01, 8'h00, 32'h0, 32'h0);
        check("lone_req0", 32'(last_ready), 32'h1);
        step(0, 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
        check("ptr_after_lone", 32'(last_ready), 32'h2);

        // Read accepted then reset: no response surfaces
        step(0, 2'b01, 2'b00, 8'h01, 8'h00, 32'h0, 32'h0);
        step(1, 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
        check("rst_kill_rv0", 32'(last_rv), 32'h0);
        idle();
        check("rst_kill_rv1", 32'(last_rv), 32'h0);
        step(0, 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
        check("rst_ptr0", 32'(last_ready), 32'h1);
        idle();

        // Read/write collision on 0x20 (pointer now at 1)
        step(0, 2'b10, 2'b10, 8'h00, 8'h20, 32'h0, 32'h00000011);
        step(0, 2'b11, 2'b10, 8'h20, 8'h20, 32'h0, 32'h00000055);
        check("coll_ready0", 32'(last_ready), 32'h1);
        step(0, 2'b10, 2'b10, 8'h00, 8'h20, 32'h0, 32'h00000055);
        check("coll_ready1", 32'(last_ready), 32'h2);
        check("coll_old", last_rd, 32'h00000011);
        step(0, 2'b01, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0);
        idle();
        check("coll_new", last_rd, 32'h00000055);

        // Idle hold (pointer at 1 after req0's last grant)
        held = last_rd;
        for (int k = 0; k < 4; k++) begin
            idle();
            check("idle_ready", 32'(last_ready), 32'h0);
            check("idle_hold", last_rd, held);
        end
        step(0, 2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
        check("idle_ptr", 32'(last_ready), 32'h2);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0),
                 2'($urandom), 2'($urandom),
                 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                 $urandom, $urandom);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
